// File: rtl/imem_loader.sv
// Byte-stream loader for the 64x32 instruction memory: packs little-endian words, writes them
// sequentially from address 0 and stalls the core meanwhile. Define IMEM_LOADER_CHECKSUM_EN to verify a trailing 32-bit sum.
module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH_WORDS = 64,
  parameter int LEN_W       = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  load_len,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_stall,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd4;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_LAST  = S_CHECK;
`else
  localparam logic [2:0] S_LAST  = S_DONE;
`endif

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_idx_q, word_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;
  logic [31:0]      word_buf_q, word_buf_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] word_idx_inc;
  logic             xfer;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      sum_q, sum_d;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
  assign cpu_stall  = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHECK);
`else
  assign byte_ready = (state_q == S_RECV);
  assign cpu_stall  = (state_q == S_RECV) || (state_q == S_WRITE);
`endif
  assign xfer         = byte_valid && byte_ready;
  assign mem_we       = (state_q == S_WRITE);
  assign mem_addr     = ADDR_W'({word_idx_q, 2'b00});
  assign mem_wdata    = word_buf_q;
  assign done         = done_q;
  assign err          = err_q;
  assign word_idx_inc = word_idx_q + LEN_W'(1);

  // NOTE: every variable gets a default at the top so no path through the case infers a latch.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_buf_d = word_buf_q;
    done_d     = done_q;
    err_d      = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          len_d      = load_len;
          word_idx_d = '0;
          byte_idx_d = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d      = '0;
`endif
          if (load_len > LEN_W'(DEPTH_WORDS)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (load_len == '0) begin
            state_d = S_LAST;
            done_d  = (S_LAST == S_DONE);
          end else begin
            state_d = S_RECV;
          end
        end
      end
      S_RECV: begin
        if (xfer) begin
          word_buf_d[8*byte_idx_q +: 8] = byte_in;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        word_idx_d = word_idx_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q + word_buf_q;
`endif
        if (word_idx_inc == len_q) begin
          state_d = S_LAST;
          done_d  = (S_LAST == S_DONE);
        end else begin
          state_d = S_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        // Trailer reuses the word buffer; the 4th byte is compared directly, not via the buffer.
        if (xfer) begin
          word_buf_d[8*byte_idx_q +: 8] = byte_in;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            if ({byte_in, word_buf_q[23:0]} != sum_q) err_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_buf_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_buf_q <= word_buf_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: vector table of loads plus hand-written corner sequences,
// with write expectations queued at drive time and compared against observed mem_we cycles.
module tb_imem_loader;

  logic        clk, rst_n, start, byte_valid;
  logic [6:0]  load_len;
  logic [7:0]  byte_in;
  logic        byte_ready, mem_we, cpu_stall, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_stall(cpu_stall), .done(done), .err(err)
  );

  typedef struct {
    int len;
    bit toggle;
    bit exp_done;
    bit exp_err;
    int exp_writes;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        ready;
    logic        fourth;
  } obs_t;

  int          checks = 0;
  int          errors = 0;
  wr_t         exp_q[$];
  obs_t        obs_q[$];
  logic [31:0] load_words [64];
  int          cur_len = 0;
  int          cur_raw = 0;
  bit          auto_trailer = 1;
  logic [7:0]  last_addr = '0;
  vec_t        vecs [7];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Observes the DUT: inputs sampled mid-low-phase, outputs 1 time unit after the rising edge.
  initial begin
    int   data_bytes;
    logic s_rst, s_start, s_stall, s_xfer, fourth;
    data_bytes = 0;
    forever begin
      @(negedge clk); #2;
      s_rst   = rst_n;
      s_start = start;
      s_stall = cpu_stall;
      s_xfer  = byte_valid && byte_ready;
      @(posedge clk); #1;
      fourth = 1'b0;
      if (!s_rst) data_bytes = 0;
      else if (s_start && !s_stall) data_bytes = 0;
      else if (s_xfer && data_bytes < 4*cur_len) begin
        data_bytes++;
        fourth = (data_bytes % 4 == 0);
      end
      if (mem_we || fourth) begin
        obs_q.push_back('{we: mem_we, addr: mem_addr, data: mem_wdata, ready: byte_ready, fourth: fourth});
        if (mem_we) last_addr = mem_addr;
      end
    end
  end

  task automatic set_default_words();
    load_words[0] = 32'h0000_7033;
    load_words[1] = 32'h0010_0093;
    for (int i = 2; i < 64; i++) load_words[i] = (i * 32'h0103_0507) ^ 32'hA5A5_0000;
  endtask

  task automatic pulse_start(input int len);
    start    = 1'b1;
    load_len = 7'(len);
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit toggle);
    int n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("byte_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    if (toggle) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit toggle);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], toggle);
  endtask

  task automatic begin_load(input int len, input int exp_writes);
    exp_q.delete();
    obs_q.delete();
    cur_raw = len;
    cur_len = (len <= 64) ? len : 0;
    for (int i = 0; i < exp_writes; i++) exp_q.push_back('{addr: 8'(4*i), data: load_words[i]});
    pulse_start(len);
  endtask

  task automatic stream(input int first_byte, input int last_byte, input bit toggle);
    for (int i = first_byte; i < last_byte; i++) begin
      logic [31:0] w;
      w = load_words[i/4];
      send_byte(w[8*(i%4) +: 8], toggle);
    end
  endtask

  task automatic finish_load(input bit exp_done, input bit exp_err, input int exp_writes);
    int          n = 0;
    logic [31:0] sum = '0;
    for (int i = 0; i < cur_len; i++) sum += load_words[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (auto_trailer && cur_raw <= 64) send_word(sum, 1'b0);
`endif
    byte_valid = 1'b0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("done", done, exp_done);
    check("err", err, exp_err);
    check("cpu_stall_after", cpu_stall, 1'b0);
    check("byte_ready_after", byte_ready, 1'b0);
    check("write_count", obs_q.size(), exp_writes);
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      obs_t o;
      wr_t  e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check("we_pulse", o.we, 1'b1);
      check("we_latency", o.fourth, 1'b1);
      check("wr_addr", o.addr, e.addr);
      check("wr_data", o.data, e.data);
      check("ready_in_write", o.ready, 1'b0);
    end
    check("missing_writes", exp_q.size(), 0);
    if (sum == 32'hFFFF_FFFF) $display("note: all-ones sum");
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    load_len   = '0;
    byte_in    = '0;
    byte_valid = 1'b0;
    set_default_words();

    vecs[0] = '{len: 2,  toggle: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 2};
    vecs[1] = '{len: 2,  toggle: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 2};
    vecs[2] = '{len: 1,  toggle: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 1};
    vecs[3] = '{len: 64, toggle: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 64};
    vecs[4] = '{len: 65, toggle: 1'b0, exp_done: 1'b1, exp_err: 1'b1, exp_writes: 0};
    vecs[5] = '{len: 0,  toggle: 1'b0, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 0};
    vecs[6] = '{len: 5,  toggle: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 5};

    repeat (2) @(negedge clk);
    check("rst_byte_ready", byte_ready, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_cpu_stall", cpu_stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      begin_load(vecs[v].len, vecs[v].exp_writes);
      if (vecs[v].len > 64) begin
        check("ovf_done_next", done, 1'b1);
        check("ovf_err_next", err, 1'b1);
        check("ovf_ready", byte_ready, 1'b0);
      end
`ifndef IMEM_LOADER_CHECKSUM_EN
      if (vecs[v].len == 0) check("len0_done_next", done, 1'b1);
`endif
      stream(0, 4*cur_len, vecs[v].toggle);
      finish_load(vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_writes);
      if (vecs[v].len == 64) check("last_addr", last_addr, 8'hFC);
    end

    // Bytes offered while DONE must be left alone.
    obs_q.delete();
    byte_in    = 8'h55;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("done_ready", byte_ready, 1'b0);
    check("done_no_we", obs_q.size(), 0);
    byte_valid = 1'b0;

    // Start pulse during RECV is ignored.
    begin_load(2, 2);
    stream(0, 2, 1'b0);
    byte_valid = 1'b0;
    pulse_start(5);
    check("ignored_start_stall", cpu_stall, 1'b1);
    stream(2, 8, 1'b0);
    finish_load(1'b1, 1'b0, 2);

    // Reset mid-RECV after two bytes: everything clears at once and partial bytes are lost.
    begin_load(1, 0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    #1;
    check("midrst_ready", byte_ready, 1'b0);
    check("midrst_stall", cpu_stall, 1'b0);
    check("midrst_we", mem_we, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load_words[0] = 32'h0020_0113;
    begin_load(1, 1);
    stream(0, 4, 1'b0);
    finish_load(1'b1, 1'b0, 1);
    set_default_words();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong trailer: sum of the two words is 0x001070C6, send 0x001070C7.
    auto_trailer = 1'b0;
    begin_load(2, 2);
    stream(0, 8, 1'b0);
    check("chk_stall", cpu_stall, 1'b1);
    send_word(32'h0010_70C7, 1'b0);
    finish_load(1'b1, 1'b1, 2);
    auto_trailer = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
